muldiv_sequencer: RTL



---
 rtl/muldiv_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one iteration per cycle, with sign fix-up and early exit for divide special cases.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       dbg_state
);

  // Handshake: an operation is accepted on a rising edge where start=1,
  // ready=1 and flush=0; done is a single-cycle pulse with result valid in it.

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         op_r;
  logic               sa, sb;
  logic [WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   quo;
  logic               done_q;

  logic               signed_a, signed_b, neg_a, neg_b, div_zero, div_ovf;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     add_hi, shifted, diff;
  logic [2*WIDTH-1:0] prod_next, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, fix_val;

  always_comb begin
    signed_a = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    signed_b = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    neg_a    = signed_a & operand_a[WIDTH-1];
    neg_b    = signed_b & operand_b[WIDTH-1];
    mag_a    = neg_a ? -operand_a : operand_a;
    mag_b    = neg_b ? -operand_b : operand_b;
    div_zero = op[2] && (operand_b == '0);
    div_ovf  = op[2] && !op[0] && (operand_a == MIN_NEG) && (operand_b == '1);
  end

  // Multiply step: add multiplicand into the high half when the multiplier LSB
  // is set, then shift the whole product right with the carry entering at the top.
  always_comb begin
    add_hi    = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, addend} : '0);
    prod_next = {add_hi, prod[WIDTH-1:1]};
    shifted   = {rem[WIDTH-1:0], quo[WIDTH-1]};
    diff      = shifted - {1'b0, addend};
  end

  always_comb begin
    prod_s  = (sa ^ sb) ? -prod : prod;
    quo_s   = (sa ^ sb) ? -quo : quo;
    rem_s   = sa ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    fix_val = '0;
    if (op_r[2])
      fix_val = op_r[1] ? rem_s : quo_s;
    else if (op_r == 3'b000)
      fix_val = prod_s[WIDTH-1:0];
    else
      fix_val = prod_s[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op_r   <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      addend <= '0;
      prod   <= '0;
      rem    <= '0;
      quo    <= '0;
      result <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (start) begin
            op_r   <= op;
            sa     <= neg_a;
            sb     <= neg_b;
            cnt    <= '0;
            addend <= op[2] ? mag_b : mag_a;
            prod   <= {{WIDTH{1'b0}}, mag_b};
            rem    <= '0;
            quo    <= mag_a;
            if (div_zero) begin
              result <= op[1] ? operand_a : '1;
              done_q <= 1'b1;
              state  <= DONE;
            end else if (div_ovf) begin
              result <= op[1] ? '0 : operand_a;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              state <= CALC;
            end
          end
          CALC: begin
            cnt <= cnt + 1'b1;
            if (op_r[2]) begin
              rem <= diff[WIDTH] ? shifted : diff;
              quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
            end else begin
              prod <= prod_next;
            end
            if (cnt == CNT_W'(WIDTH-1))
              state <= FIX;
          end
          FIX: begin
            result <= fix_val;
            done_q <= 1'b1;
            state  <= DONE;
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // A flush arriving in the DONE cycle itself also suppresses the pulse.
  assign done      = done_q & ~flush;
  assign ready     = (state == IDLE);
  assign busy      = ~ready;
  assign dbg_state = state;

endmodule
